// File: rtl/ip4_axi_wr_slv.sv
// AXI3 write-channel slave: accepts one AW/W burst at a time, turns each beat into a
// registered word write on the local memory port and returns one B response per burst.
module ip4_axi_wr_slv #(
  parameter int WID_AXI_ID     = 4,
  parameter int WID_AXI_DATA   = 32,
  parameter int WID_AXI_ADDR   = 32,
  parameter int BYTES_AXI_DATA = WID_AXI_DATA / 8,
  parameter int MEM_AW         = 8
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [WID_AXI_ID-1:0]     awid,
  input  logic [WID_AXI_ADDR-1:0]   awaddr,
  input  logic [3:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [WID_AXI_ID-1:0]     wid,
  input  logic [WID_AXI_DATA-1:0]   wdata,
  input  logic [BYTES_AXI_DATA-1:0] wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [WID_AXI_ID-1:0]     bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      mem_we,
  output logic [MEM_AW-1:0]         mem_addr,
  output logic [WID_AXI_DATA-1:0]   mem_wdata,
  output logic [BYTES_AXI_DATA-1:0] mem_be
);

  localparam int         OFFW     = $clog2(BYTES_AXI_DATA);
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);

  // state  | meaning
  // S_IDLE | awready high, waiting for a burst address
  // S_DATA | wready high, one beat per cycle until len or wlast
  // S_RESP | bvalid high with bid/bresp held until bready
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;

  state_e                    state_q, state_d;
  logic [WID_AXI_ID-1:0]     id_q, id_d;
  logic [WID_AXI_ADDR-1:0]   addr_q, addr_d;
  logic [3:0]                len_q, len_d, cnt_q, cnt_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic                      slverr_q, slverr_d, decerr_q, decerr_d, suppress_q, suppress_d;
  logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [WID_AXI_ID-1:0]     bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]         mem_addr_q, mem_addr_d;
  logic [WID_AXI_DATA-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BYTES_AXI_DATA-1:0] mem_be_q, mem_be_d;

  logic [2:0]                size_eff, aw_size_eff;
  logic [WID_AXI_ADDR-1:0]   nb, aw_nb, addr_align, wrap_mask, addr_next;
  logic [BYTES_AXI_DATA-1:0] lane_mask;
  logic                      beat_decerr, aw_szerr, beat_last, beat_slv;

  // Illegal sizes are clamped so the shift arithmetic stays bounded; such bursts never write.
  always_comb begin
    size_eff    = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
    nb          = WID_AXI_ADDR'(1) << size_eff;
    addr_align  = addr_q & ~(nb - WID_AXI_ADDR'(1));
    lane_mask   = (~({BYTES_AXI_DATA{1'b1}} << nb)) << addr_align[OFFW-1:0];
    wrap_mask   = ((WID_AXI_ADDR'(len_q) + WID_AXI_ADDR'(1)) << size_eff) - WID_AXI_ADDR'(1);
    case (burst_q)
      2'b01:   addr_next = addr_align + nb;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + nb) & wrap_mask);
      default: addr_next = addr_q;
    endcase
    beat_decerr = (addr_q >> (MEM_AW + OFFW)) != '0;

    aw_size_eff = (awsize > MAX_SIZE) ? MAX_SIZE : awsize;
    aw_nb       = WID_AXI_ADDR'(1) << aw_size_eff;
    aw_szerr    = (awsize > MAX_SIZE) || (awburst == 2'b11) ||
                  ((awburst == 2'b10) &&
                   (((awlen != 4'd1) && (awlen != 4'd3) && (awlen != 4'd7) && (awlen != 4'd15)) ||
                    ((awaddr & (aw_nb - WID_AXI_ADDR'(1))) != '0)));
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    slverr_d    = slverr_q;
    decerr_d    = decerr_q;
    suppress_d  = suppress_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    beat_last   = (cnt_q == len_q);
    beat_slv    = (wid != id_q) || (wlast != beat_last);

    case (state_q)
      S_IDLE: begin
        if (awvalid && awready_q) begin
          id_d       = awid;
          addr_d     = awaddr;
          len_d      = awlen;
          size_d     = awsize;
          burst_d    = awburst;
          cnt_d      = '0;
          slverr_d   = aw_szerr;
          suppress_d = aw_szerr;
          decerr_d   = 1'b0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (wvalid && wready_q) begin
          // ID and wlast mismatches only flag the response; the data is still written.
          mem_we_d    = !suppress_q && !beat_decerr;
          mem_addr_d  = addr_q[OFFW +: MEM_AW];
          mem_wdata_d = wdata;
          mem_be_d    = wstrb & lane_mask;
          addr_d      = addr_next;
          cnt_d       = cnt_q + 4'd1;
          slverr_d    = slverr_q | beat_slv;
          decerr_d    = decerr_q | beat_decerr;
          if (beat_last || wlast) begin
            state_d = S_RESP;
            bid_d   = id_q;
            bresp_d = decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
          end
        end
      end
      S_RESP: begin
        if (bvalid_q && bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      slverr_q    <= 1'b0;
      decerr_q    <= 1'b0;
      suppress_q  <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      slverr_q    <= slverr_d;
      decerr_q    <= decerr_d;
      suppress_q  <= suppress_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: doc/ip4_axi_wr_slv.md
Name: ip4_axi_wr_slv

Overview:
- AXI3 write-channel responder (AW, W, B) for the ip4 AXI port; the slave end of the write path driven by ip4 AXI masters.
- Accepts one write burst at a time and converts each beat into a registered write to a local word-addressed memory/register port.
- Returns one B response per burst.
- Supports FIXED, INCR and WRAP bursts, 1-16 beats, and narrow sizes.

Parameters:
WID_AXI_ID, 4, ID width
WID_AXI_DATA, 32, data width (power of two, 32..128)
WID_AXI_ADDR, 32, byte address width
BYTES_AXI_DATA, WID_AXI_DATA/8, strobe width
MEM_AW, 8, memory word-address width (2^MEM_AW words)

Ports:
aclk  input  1  clock
rst  input  1  asynchronous active-high reset
awid  input  WID_AXI_ID  write address ID
awaddr  input  WID_AXI_ADDR  burst start byte address
awlen  input  4  beats-1
awsize  input  3  log2 bytes per beat
awburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  input  1  AW valid
awready  output  1  AW ready
wid  input  WID_AXI_ID  write data ID
wdata  input  WID_AXI_DATA  write data
wstrb  input  BYTES_AXI_DATA  byte strobes
wlast  input  1  last beat
wvalid  input  1  W valid
wready  output  1  W ready
bid  output  WID_AXI_ID  response ID (= captured awid)
bresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid  output  1  B valid
bready  input  1  B ready
mem_we  output  1  memory write strobe
mem_addr  output  MEM_AW  memory word address
mem_wdata  output  WID_AXI_DATA  memory write data
mem_be  output  BYTES_AXI_DATA  memory byte enables

Behaviour:
- Clock is aclk. Reset is asynchronous, active-high, on rst.
- All outputs are registered. Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=00, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. State=IDLE, error flags cleared.
- Reset mid-burst: state goes to IDLE immediately. No further mem_we. Pending B response is discarded.

FSM:
- IDLE: awready=1 (first cycle after reset release: 0, then 1).
  - On awvalid&awready: capture id/addr/len/size/burst, clear beat counter and error flags, deassert awready, go to DATA.
- DATA: wready=1.
  - Each wvalid&wready is one beat; beat counter increments.
  - Exit to RESP after the beat where counter==len, or after an earlier beat with wlast=1, whichever comes first. wready drops in RESP.
- RESP: bvalid=1; bid and bresp are stable until bready. On bvalid&bready, go to IDLE; awready=1 on the next cycle.
- Sustained throughput: one beat per cycle. Per-burst overhead is 1 cycle AW plus ≥1 cycle B. awvalid is never accepted outside IDLE.

Beat write:
- mem_we=1 exactly one cycle after an accepted beat, with that beat's registered mem_addr/mem_wdata/mem_be.
- mem_addr = current byte address >> log2(BYTES_AXI_DATA), truncated to MEM_AW.
- mem_be = wstrb AND lane mask. The lane mask covers the 2^size bytes starting at (address mod BYTES_AXI_DATA) aligned down to size.

Address update after each beat:
- FIXED: unchanged.
- INCR: aligned(addr) + 2^size. First beat may be unaligned; later beats aligned.
- WRAP: container = (len+1)*2^size. Next = lower-bits increment modulo container, upper bits held.

Errors (flags sticky per burst):
- SLVERR:
  - awsize > log2(BYTES_AXI_DATA)
  - awburst=11
  - WRAP with len not in {1,3,7,15} or unaligned start
  - wid != captured awid on any beat
  - wlast=1 before the final beat, or wlast=0 on the final beat
  - With a size/burst error, every beat is consumed with mem_we suppressed.
- DECERR: awaddr bits at and above MEM_AW+log2(BYTES_AXI_DATA) are nonzero. Checked per beat; that beat's mem_we is suppressed.
- bresp priority: DECERR > SLVERR > OKAY.
- wid mismatch and wlast mismatch do not suppress the write.
- Early wlast terminates the burst; remaining beats are not awaited.
- INCR crossing the memory top: later beats get DECERR per the address check.

Test Plan:
- Reset then INCR len=3 size=2 awaddr=0x10 wstrb=F, wdata 0xA0..0xA3, bready=1 → mem_we on 4 consecutive cycles at addr 4,5,6,7; bvalid with bid=awid, bresp=00.
- WRAP len=3 size=2 awaddr=0x18 → mem_addr 6,7,4,5, OKAY. Repeat with awaddr=0x1A → no mem_we, bresp=10.
- Narrow INCR size=0 len=3 awaddr=0x01 wstrb=F → mem_be 0010,0100,1000,0001; addresses 0,0,0,1.
- awaddr=0x400 (MEM_AW=8, 32-bit) len=0 → no mem_we, bresp=11. wid≠awid on beat 1 of len=1 → both beats written, bresp=10.
- bready held 0 for 5 cycles with a new awvalid pending → bid/bresp stable, awready=0 throughout; awready=1 the cycle after handshake.
- rst asserted during beat 2 of a len=7 burst → all outputs 0 asynchronously, no further mem_we; next burst completes OKAY.
